// File: rtl/mips_pipe_pkg.sv
// Shared opcodes, ALU codes, instruction field positions and decode for the
// 3-stage MIPS-subset pipeline (mips_pipe3_core, optional FORWARD_EN bypass).
package mips_pipe_pkg;

  localparam int unsigned IR_W   = 16;
  localparam int unsigned IMM_W  = 8;

  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 12;
  localparam int unsigned RS_HI  = 11;
  localparam int unsigned RS_LO  = 10;
  localparam int unsigned RT_HI  = 9;
  localparam int unsigned RT_LO  = 8;
  localparam int unsigned RD_HI  = 7;
  localparam int unsigned RD_LO  = 6;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  localparam logic [IR_W-1:0] NOP = 16'h0000;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       use_imm;
    logic       wr_en;
    logic [1:0] dest;
    logic       is_beq;
    logic       is_bne;
  } ctrl_t;

  // Undefined opcodes decode to a non-writing, non-branching ADD.
  function automatic ctrl_t decode(input logic [IR_W-1:0] ir);
    ctrl_t c;
    c.alu_op  = ALU_ADD;
    c.use_imm = 1'b0;
    c.wr_en   = 1'b0;
    c.dest    = ir[RD_HI:RD_LO];
    c.is_beq  = 1'b0;
    c.is_bne  = 1'b0;
    case (ir[OP_HI:OP_LO])
      OP_ADD: c.wr_en = 1'b1;
      OP_SUB: begin
        c.alu_op = ALU_SUB;
        c.wr_en  = 1'b1;
      end
      OP_AND: begin
        c.alu_op = ALU_AND;
        c.wr_en  = 1'b1;
      end
      OP_OR: begin
        c.alu_op = ALU_OR;
        c.wr_en  = 1'b1;
      end
      OP_SLT: begin
        c.alu_op = ALU_SLT;
        c.wr_en  = 1'b1;
      end
      OP_ADDI: begin
        c.use_imm = 1'b1;
        c.wr_en   = 1'b1;
        c.dest    = ir[RT_HI:RT_LO];
      end
      OP_BEQ: begin
        c.alu_op = ALU_SUB;
        c.is_beq = 1'b1;
      end
      OP_BNE: begin
        c.alu_op = ALU_SUB;
        c.is_bne = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_pipe_alu.sv
// DATA_W-wide ALU; SUB and SLT share the subtractor, slt is the signed less-than flag.
module mips_pipe_alu
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero,
  output logic              slt
);

  always_comb begin
    y = a + b;
    case (op)
      ALU_AND:          y = a & b;
      ALU_OR:           y = a | b;
      ALU_SUB, ALU_SLT: y = a - b;
      default:          y = a + b;
    endcase
  end

  assign zero = (y == '0);
  assign slt  = ($signed(a) < $signed(b));

endmodule

// File: rtl/mips_pipe3_core.sv
// 3-stage (IF, ID, EX/WB) MIPS-subset core with branch flush in EX and run/hold.
// Define FORWARD_EN to bypass the EX write-back result into the ID register read.
module mips_pipe3_core
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned IMEM_AW = 10,
  parameter int unsigned RET_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic [IMEM_AW:0]   pc,
  output logic [15:0]        ifid_ir,
  output logic [15:0]        idex_ir,
  output logic               wb_en,
  output logic [1:0]         wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic [RET_W-1:0]   retired
);

  localparam int unsigned PC_W = IMEM_AW + 1;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IR_W-1:0]   ifid_ir_q, ifid_ir_d;
  logic [PC_W-1:0]   ifid_npc_q, ifid_npc_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [IR_W-1:0]   idex_ir_q, idex_ir_d;
  logic [PC_W-1:0]   idex_npc_q, idex_npc_d;
  logic              idex_valid_q, idex_valid_d;
  logic [DATA_W-1:0] idex_a_q, idex_a_d;
  logic [DATA_W-1:0] idex_b_q, idex_b_d;
  logic [DATA_W-1:0] idex_imm_q, idex_imm_d;
  ctrl_t             idex_ctrl_q, idex_ctrl_d;
  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] rf_d [4];
  logic [RET_W-1:0]  retired_q, retired_d;

  // ID: decode, register read, sign-extend
  ctrl_t             id_ctrl;
  logic [1:0]        id_rs, id_rt;
  logic [DATA_W-1:0] id_a, id_b, id_imm;

  assign id_ctrl = decode(ifid_ir_q);
  assign id_rs   = ifid_ir_q[RS_HI:RS_LO];
  assign id_rt   = ifid_ir_q[RT_HI:RT_LO];
  assign id_imm  = {{(DATA_W-IMM_W){ifid_ir_q[IMM_HI]}}, ifid_ir_q[IMM_HI:IMM_LO]};

`ifdef FORWARD_EN
  assign id_a = (wb_en && (wb_addr == id_rs)) ? wb_data : rf_q[id_rs];
  assign id_b = (wb_en && (wb_addr == id_rt)) ? wb_data : rf_q[id_rt];
`else
  assign id_a = rf_q[id_rs];
  assign id_b = rf_q[id_rt];
`endif

  // EX/WB
  logic [DATA_W-1:0] alu_b, alu_y;
  logic              alu_zero, alu_slt, br_taken;
  logic [PC_W-1:0]   br_target;

  assign alu_b = idex_ctrl_q.use_imm ? idex_imm_q : idex_b_q;

  mips_pipe_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (idex_ctrl_q.alu_op),
    .a    (idex_a_q),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero),
    .slt  (alu_slt)
  );

  assign br_taken  = idex_valid_q & ((idex_ctrl_q.is_beq & alu_zero) |
                                     (idex_ctrl_q.is_bne & ~alu_zero));
  // Immediate is already sign-extended, so its low bits form the halfword offset.
  assign br_target = idex_npc_q + {idex_imm_q[PC_W-2:0], 1'b0};

  assign wb_en   = run & idex_valid_q & idex_ctrl_q.wr_en & (idex_ctrl_q.dest != 2'd0);
  assign wb_addr = idex_ctrl_q.dest;
  assign wb_data = (idex_ctrl_q.alu_op == ALU_SLT) ? DATA_W'(alu_slt) : alu_y;

  always_comb begin
    pc_d         = pc_q;
    ifid_ir_d    = ifid_ir_q;
    ifid_npc_d   = ifid_npc_q;
    ifid_valid_d = ifid_valid_q;
    idex_ir_d    = idex_ir_q;
    idex_npc_d   = idex_npc_q;
    idex_valid_d = idex_valid_q;
    idex_a_d     = idex_a_q;
    idex_b_d     = idex_b_q;
    idex_imm_d   = idex_imm_q;
    idex_ctrl_d  = idex_ctrl_q;
    rf_d         = rf_q;
    retired_d    = retired_q;
    if (run) begin
      retired_d = retired_q + RET_W'(idex_valid_q);
      if (wb_en) rf_d[wb_addr] = wb_data;
      if (br_taken) begin
        pc_d         = br_target;
        ifid_ir_d    = NOP;
        ifid_valid_d = 1'b0;
        idex_ir_d    = NOP;
        idex_valid_d = 1'b0;
      end else begin
        pc_d         = pc_q + PC_W'(2);
        ifid_ir_d    = imem_rdata;
        ifid_npc_d   = pc_q + PC_W'(2);
        ifid_valid_d = 1'b1;
        idex_ir_d    = ifid_ir_q;
        idex_npc_d   = ifid_npc_q;
        idex_valid_d = ifid_valid_q;
        idex_a_d     = id_a;
        idex_b_d     = id_b;
        idex_imm_d   = id_imm;
        idex_ctrl_d  = id_ctrl;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= '0;
      ifid_ir_q    <= NOP;
      ifid_npc_q   <= '0;
      ifid_valid_q <= 1'b0;
      idex_ir_q    <= NOP;
      idex_npc_q   <= '0;
      idex_valid_q <= 1'b0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      idex_imm_q   <= '0;
      idex_ctrl_q  <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      retired_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_ir_q    <= ifid_ir_d;
      ifid_npc_q   <= ifid_npc_d;
      ifid_valid_q <= ifid_valid_d;
      idex_ir_q    <= idex_ir_d;
      idex_npc_q   <= idex_npc_d;
      idex_valid_q <= idex_valid_d;
      idex_a_q     <= idex_a_d;
      idex_b_q     <= idex_b_d;
      idex_imm_q   <= idex_imm_d;
      idex_ctrl_q  <= idex_ctrl_d;
      rf_q         <= rf_d;
      retired_q    <= retired_d;
    end
  end

  assign imem_addr = pc_q[PC_W-1:1];
  assign pc        = pc_q;
  assign ifid_ir   = ifid_ir_q;
  assign idex_ir   = idex_ir_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mips_pipe3_core.sv
// Bench for mips_pipe3_core: directed programs plus random programs checked against
// an instruction-level reference model; honours FORWARD_EN for hazard generation.
module tb_mips_pipe3_core;

  localparam int unsigned AW     = 10;
  localparam int unsigned NWORDS = 1 << AW;
  localparam int unsigned PCMOD  = 2 * NWORDS;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b1;
  logic run   = 1'b0;

  logic [15:0] imem  [NWORDS];
  logic [15:0] imem2 [NWORDS];

  logic [AW-1:0] imem_addr, imem_addr2;
  logic [15:0]   imem_rdata, imem_rdata2;
  logic [AW:0]   pc, pc2;
  logic [15:0]   ifid_ir, idex_ir, ifid_ir2, idex_ir2;
  logic          wb_en, wb_en2;
  logic [1:0]    wb_addr, wb_addr2;
  logic [15:0]   wb_data;
  logic [31:0]   wb_data2;
  logic [15:0]   retired, retired2;

  assign imem_rdata  = imem[imem_addr];
  assign imem_rdata2 = imem2[imem_addr2];

  mips_pipe3_core #(.DATA_W(16), .IMEM_AW(AW), .RET_W(16)) dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .ifid_ir(ifid_ir), .idex_ir(idex_ir),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .retired(retired)
  );

  mips_pipe3_core #(.DATA_W(32), .IMEM_AW(AW), .RET_W(16)) dut32 (
    .clock(clock), .reset(reset), .run(run),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .pc(pc2),
    .ifid_ir(ifid_ir2), .idex_ir(idex_ir2),
    .wb_en(wb_en2), .wb_addr(wb_addr2), .wb_data(wb_data2), .retired(retired2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: architectural state plus pending bubble slots
  int          m_pc;
  int          m_bub;
  logic [15:0] m_regs [4];
  logic [15:0] m_ret;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  function automatic logic [15:0] fetch(input int byte_pc);
    return imem[(byte_pc / 2) % NWORDS];
  endfunction

  task automatic model_reset();
    m_pc  = 0;
    m_bub = 2;
    for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
    m_ret = 16'h0;
    q1.delete();
    q2.delete();
  endtask

  task automatic cycle(input logic run_v, input logic rst_v);
    logic [15:0] ir, a, b, res;
    int op, dest, s, tgt;
    bit wr, tk, exp_en;
    @(negedge clock);
    run   = run_v;
    reset = rst_v;
    #1;
    if (rst_v) begin
      model_reset();
      return;
    end
    if (wb_en)  q1.push_back(32'(wb_data));
    if (wb_en2) q2.push_back(wb_data2);
    chk("pc", 64'(pc), 64'((m_pc + 4 - 2 * m_bub) % PCMOD));
    chk("ifid_ir", 64'(ifid_ir), (m_bub == 2) ? 64'h0 : 64'(fetch(m_pc + 2 - 2 * m_bub)));
    chk("idex_ir", 64'(idex_ir), (m_bub > 0) ? 64'h0 : 64'(fetch(m_pc)));
    chk("retired", 64'(retired), 64'(m_ret));
    ir = fetch(m_pc);
    op = int'(ir[15:12]);
    a  = m_regs[ir[11:10]];
    b  = m_regs[ir[9:8]];
    s  = int'($signed(ir[7:0]));
    wr = 1'b0; tk = 1'b0; res = 16'h0; dest = int'(ir[7:6]);
    case (op)
      0: begin wr = 1'b1; res = a + b; end
      1: begin wr = 1'b1; res = a - b; end
      2: begin wr = 1'b1; res = a & b; end
      3: begin wr = 1'b1; res = a | b; end
      7: begin wr = 1'b1; res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0; end
      4: begin wr = 1'b1; res = a + 16'(s); dest = int'(ir[9:8]); end
      8: tk = (a == b);
      9: tk = (a != b);
      default: ;
    endcase
    exp_en = run_v && (m_bub == 0) && wr && (dest != 0);
    chk("wb_en", 64'(wb_en), 64'(exp_en));
    if (exp_en) begin
      chk("wb_addr", 64'(wb_addr), 64'(dest));
      chk("wb_data", 64'(wb_data), 64'(res));
    end
    if (run_v) begin
      if (m_bub > 0) m_bub--;
      else begin
        if (wr && dest != 0) m_regs[dest] = res;
        m_ret = m_ret + 16'd1;
        if (tk) begin
          tgt   = m_pc + 2 + 2 * s;
          m_pc  = ((tgt % PCMOD) + PCMOD) % PCMOD;
          m_bub = 2;
        end else m_pc = (m_pc + 2) % PCMOD;
      end
    end
  endtask

  task automatic check_seq(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
    chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, 64'(got[i]), 64'(exp[i]));
  endtask

  function automatic int wdest(input logic [15:0] ir);
    case (ir[15:12])
      4'd0, 4'd1, 4'd2, 4'd3, 4'd7: return int'(ir[7:6]);
      4'd4:                         return int'(ir[9:8]);
      default:                      return 0;
    endcase
  endfunction

  function automatic bit reads_reg(input logic [15:0] ir, input int r);
    case (ir[15:12])
      4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9:
        return (int'(ir[11:10]) == r) || (int'(ir[9:8]) == r);
      4'd4:    return int'(ir[11:10]) == r;
      default: return 1'b0;
    endcase
  endfunction

  // Without bypass, no instruction may read what its predecessor writes
  function automatic logic [15:0] rand_instr(input logic [15:0] prev);
    logic [15:0] ir;
    int d;
    d = wdest(prev);
    for (int t = 0; t < 50; t++) begin
      ir = 16'($urandom);
      if (FWD || d == 0 || !reads_reg(ir, d)) return ir;
    end
    return 16'h0000;
  endfunction

  logic [15:0] arith_prog [8] = '{16'h410F, 16'h4207, 16'h26C0, 16'h1780,
                                  16'h3B80, 16'h0BC0, 16'h7E40, 16'h7B40};
  logic [31:0] exp_arith[$] = '{32'd15, 32'd7, 32'd7, 32'd8, 32'd15, 32'd22, 32'd0, 32'd1};
  logic [31:0] exp_beq[$]   = '{32'd5, 32'd5, 32'd9};
  logic [31:0] exp_bne[$]   = '{32'd5, 32'd5, 32'd1, 32'd2, 32'd9};
  logic [31:0] exp_w32[$]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

  task automatic clear_imem();
    for (int i = 0; i < NWORDS; i++) imem[i] = 16'h0000;
  endtask

  task automatic load_arith();
    clear_imem();
    for (int i = 0; i < 8; i++) imem[FWD ? i : 2 * i] = arith_prog[i];
  endtask

  task automatic load_branch(input logic [15:0] br);
    clear_imem();
    imem[0] = 16'h4105; imem[2] = 16'h4205; imem[4] = br;
    imem[5] = 16'h4301; imem[6] = 16'h4302; imem[7] = 16'h4109;
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) imem2[i] = 16'h0000;
    imem2[0] = 16'h41FF; imem2[2] = 16'h0580; imem2[4] = 16'h74C0;
    model_reset();

    // Straight-line ALU program and the 32-bit datapath instance
    load_arith();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
    check_seq("arith_seq", q1, exp_arith);
    check_seq("w32_seq", q2, exp_w32);

    // Taken beq flushes two slots; bne falls through
    load_branch(16'h8602);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    check_seq("beq_seq", q1, exp_beq);
    load_branch(16'h9602);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    check_seq("bne_seq", q1, exp_bne);

    // Hold mid-program
    load_arith();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0);
    check_seq("hold_seq", q1, exp_arith);

    // Reset mid-program restarts from pc 0
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
    check_seq("rerun_seq", q1, exp_arith);

    // Random programs with random hold and occasional reset
    imem[0] = 16'h0000;
    for (int i = 1; i < NWORDS; i++) imem[i] = rand_instr(imem[i-1]);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
